profile_stats: RTL

//  Downstream of the bkg-subtraction + 32->16 width-conversion stage. Consumes one
//  16-bit background-subtracted fibre-profile packet per frame and reduces it to a
//  5-word 32-bit result packet: header, sum, first moment (hi/lo) and peak.
//  The result feeds the position/readout FIFO.

---
 rtl/profile_stats_pkg.sv | 29 ++
 rtl/profile_accum.sv | 64 ++++++
 rtl/profile_stats.sv | 106 ++++++++++
 3 files changed

// File: rtl/profile_stats_pkg.sv
// profile_stats_pkg: shared constants for the fibre-profile statistics block
package profile_stats_pkg;

    localparam int N_WORDS = 5;

    localparam logic [2:0] W_HDR    = 3'd0;
    localparam logic [2:0] W_SUM    = 3'd1;
    localparam logic [2:0] W_MOM_HI = 3'd2;
    localparam logic [2:0] W_MOM_LO = 3'd3;
    localparam logic [2:0] W_PEAK   = 3'd4;

    localparam int HDR_ERR_SHORT = 31;
    localparam int HDR_ERR_LONG  = 30;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_EMIT  = 2'd3;

    function automatic logic [31:0] hdr_word(input logic err_short, input logic err_long,
                                             input logic [15:0] frame_cnt);
        logic [31:0] w;
        w = {16'd0, frame_cnt};
        w[HDR_ERR_SHORT] = err_short;
        w[HDR_ERR_LONG]  = err_long;
        return w;
    endfunction

endpackage

// File: rtl/profile_accum.sv
// profile_accum: sum, registered product, first moment and peak datapath for one frame
module profile_accum
    import profile_stats_pkg::*;
#(
    parameter bit CLIP_NEG = 1'b1,
    parameter int MOM_W    = 48
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic [15:0]             idx_i,
    input  logic signed [15:0]      sample_i,
    output logic [31:0]             sum_o,
    output logic [MOM_W-1:0]        mom_o,
    output logic [15:0]             peak_idx_o,
    output logic signed [15:0]      peak_val_o
);

    logic signed [15:0] s_c;
    logic signed [32:0] prod_d, prod_q;
    logic               prod_v_q;
    logic [31:0]        sum_d, sum_q;
    logic [MOM_W-1:0]   mom_d, mom_q;
    logic [15:0]        pk_idx_d, pk_idx_q;
    logic signed [15:0] pk_val_d, pk_val_q;
    logic               pk_ld;

    // Clear and a new beat may coincide (restart): old state is dropped, the new sample kept.
    always_comb begin
        s_c      = (CLIP_NEG && sample_i < 16'sd0) ? 16'sd0 : sample_i;
        prod_d   = 33'(s_c) * 33'($signed({1'b0, idx_i}));
        sum_d    = (clr_i ? 32'd0 : sum_q) + (en_i ? 32'(s_c) : 32'd0);
        mom_d    = (clr_i ? '0 : mom_q) + ((prod_v_q && !clr_i) ? MOM_W'(prod_q) : '0);
        pk_ld    = en_i && (idx_i == 16'd0 || s_c > pk_val_q);
        pk_idx_d = pk_ld ? idx_i : (clr_i ? 16'd0 : pk_idx_q);
        pk_val_d = pk_ld ? s_c : (clr_i ? 16'sd0 : pk_val_q);
    end

    // Accumulator state; the product lags its sample by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_q   <= '0;
            prod_v_q <= 1'b0;
            sum_q    <= '0;
            mom_q    <= '0;
            pk_idx_q <= '0;
            pk_val_q <= '0;
        end else begin
            prod_q   <= prod_d;
            prod_v_q <= en_i;
            sum_q    <= sum_d;
            mom_q    <= mom_d;
            pk_idx_q <= pk_idx_d;
            pk_val_q <= pk_val_d;
        end
    end

    assign sum_o      = sum_q;
    assign mom_o      = mom_q;
    assign peak_idx_o = pk_idx_q;
    assign peak_val_o = pk_val_q;

endmodule

// File: rtl/profile_stats.sv
// profile_stats: reduces one fibre-profile frame to a 5-word statistics packet
module profile_stats
    import profile_stats_pkg::*;
#(
    parameter int N_CH     = 320,
    parameter bit CLIP_NEG = 1'b1,
    parameter int MOM_W    = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_in_data,
    output logic        data_in_ready,
    input  logic        data_in_valid,
    input  logic [1:0]  data_in_empty,
    input  logic        data_in_startofpacket,
    input  logic        data_in_endofpacket,
    output logic [31:0] data_out_data,
    input  logic        data_out_ready,
    output logic        data_out_valid,
    output logic [1:0]  data_out_empty,
    output logic        data_out_startofpacket,
    output logic        data_out_endofpacket
);

    localparam logic [15:0] N_LAST = 16'(N_CH - 1);

    logic [1:0]         st_d, st_q;
    logic [15:0]        idx_d, idx_q, cur_idx;
    logic [2:0]         word_d, word_q;
    logic [15:0]        fc_d, fc_q;
    logic               es_d, es_q, el_d, el_q;
    logic               beat, in_frame, acc_en, acc_clr, done;
    logic [31:0]        sum;
    logic [MOM_W-1:0]   mom;
    logic [15:0]        pk_idx;
    logic signed [15:0] pk_val;
    logic               unused_empty;

    assign unused_empty = ^data_in_empty;

    profile_accum #(.CLIP_NEG(CLIP_NEG), .MOM_W(MOM_W)) u_accum (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (acc_clr),
        .en_i       (acc_en),
        .idx_i      (cur_idx),
        .sample_i   (data_in_data),
        .sum_o      (sum),
        .mom_o      (mom),
        .peak_idx_o (pk_idx),
        .peak_val_o (pk_val)
    );

    // Frame tracking: a sop always restarts at idx 0; idx saturates at N_CH so overlong frames only flag.
    always_comb begin
        data_in_ready = (st_q == ST_IDLE) || (st_q == ST_ACCUM);
        beat     = data_in_valid && data_in_ready;
        in_frame = beat && (data_in_startofpacket || st_q == ST_ACCUM);
        cur_idx  = data_in_startofpacket ? 16'd0 : idx_q;
        acc_en   = in_frame && cur_idx <= N_LAST;
        done     = st_q == ST_EMIT && data_out_ready && word_q == W_PEAK;
        acc_clr  = (st_q == ST_ACCUM && beat && data_in_startofpacket) || done;
        idx_d    = in_frame ? (cur_idx <= N_LAST ? cur_idx + 16'd1 : cur_idx) : idx_q;
        el_d     = done ? 1'b0 : in_frame ? ((!data_in_startofpacket && el_q) || cur_idx > N_LAST) : el_q;
        es_d     = done ? 1'b0 : in_frame ? (data_in_endofpacket && cur_idx < N_LAST) : es_q;
        st_d     = (st_q == ST_FLUSH) ? ST_EMIT :
                   (st_q == ST_EMIT)  ? (done ? ST_IDLE : ST_EMIT) :
                   in_frame           ? (data_in_endofpacket ? ST_FLUSH : ST_ACCUM) : st_q;
        word_d   = (st_q == ST_EMIT && data_out_ready) ? (done ? W_HDR : word_q + 3'd1) : word_q;
        fc_d     = done ? fc_q + 16'd1 : fc_q;
    end

    // Control state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q   <= ST_IDLE;
            idx_q  <= '0;
            word_q <= W_HDR;
            fc_q   <= '0;
            es_q   <= 1'b0;
            el_q   <= 1'b0;
        end else begin
            st_q   <= st_d;
            idx_q  <= idx_d;
            word_q <= word_d;
            fc_q   <= fc_d;
            es_q   <= es_d;
            el_q   <= el_d;
        end
    end

    // Result word mux; accumulators are frozen during EMIT so words stay stable under backpressure.
    always_comb begin
        data_out_valid         = st_q == ST_EMIT;
        data_out_empty         = 2'd0;
        data_out_startofpacket = data_out_valid && word_q == W_HDR;
        data_out_endofpacket   = data_out_valid && word_q == W_PEAK;
        data_out_data          = !data_out_valid     ? 32'd0 :
                                 (word_q == W_HDR)    ? hdr_word(es_q, el_q, fc_q) :
                                 (word_q == W_SUM)    ? sum :
                                 (word_q == W_MOM_HI) ? 32'(mom[MOM_W-1:32]) :
                                 (word_q == W_MOM_LO) ? mom[31:0] :
                                                        {pk_idx, pk_val};
    end

endmodule
